id_stage_fwd: RTL
=================

Name: id_stage_fwd

Overview:
- Next-generation decode stage, parametrised in data width, forwarding channel count and branch-resolution mode.
- Sits between the IF/ID register and EX. Decodes RV32I formats (U, J, I, S, B, R) and reads the regfile combinationally.
- Resolves operands through an N-channel forwarding network and detects load-use hazards internally.
- Holds its result in an output pipeline register with a valid/ready handshake, so no separate id_ex register is needed.
- Resolves JAL/JALR/branches in ID when enabled.

Parameters:
- XLEN, 32, data/address width.
- REG_AW, 5, register address width.
- NUM_FWD, 2, forwarding channels; index 0 is the youngest and has the highest priority.
- BRANCH_IN_ID, 1, 1 = resolve branches/jumps in ID; 0 = pass them to EX with jump_o held at 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  pc_i/inst_i valid.
- in_ready  out  1  instruction accepted this cycle when in_valid is also high.
- pc_i  in  XLEN  instruction PC.
- inst_i  in  32  instruction word.
- flush_i  in  1  kill the instruction in ID and the output register.
- rs1_addr_o  out  REG_AW  regfile read address 1.
- rs2_addr_o  out  REG_AW  regfile read address 2.
- rs1_data_i  in  XLEN  regfile read data 1.
- rs2_data_i  in  XLEN  regfile read data 2.
- fwd_valid_i  in  NUM_FWD  channel carries a register write.
- fwd_pend_i  in  NUM_FWD  channel result not yet available (load in flight).
- fwd_addr_i  in  NUM_FWD*REG_AW  channel destination addresses.
- fwd_data_i  in  NUM_FWD*XLEN  channel write data.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  EX accepts the output register.
- pc_o  out  XLEN  registered PC.
- aluop_o  out  7  registered opcode.
- funct3_o  out  3  registered funct3.
- funct7_o  out  7  registered funct7.
- op1_o  out  XLEN  registered operand 1.
- op2_o  out  XLEN  registered operand 2.
- imm_o  out  XLEN  registered immediate.
- wreg_o  out  1  registered write enable.
- wd_o  out  REG_AW  registered destination register.
- illegal_o  out  1  registered flag: opcode not decoded.
- jump_o  out  1  combinational redirect pulse.
- jpc_o  out  XLEN  combinational redirect target.
- stall_cnt_o  out  32  count of hazard-stall cycles.

Behaviour:
- Reset (rst==0 at a clk edge) clears out_valid, all registered outputs, illegal_o and stall_cnt_o to 0. A reset mid-stall drops the held instruction.
- Immediates: standard RV32I sign extension per format; B and J immediates have bit 0 = 0; U immediate is {inst[31:12], 12'b0}.
- Reads:
  - rs1 is used by R/I/S/B types.
  - rs2 is used by R/S/B types.
  - Unused reads drive address 0.
- Operand resolution, per source, first match wins:
  - address 0 gives 0;
  - lowest-index channel with fwd_valid_i set and fwd_addr_i equal to the source address gives fwd_data_i;
  - otherwise regfile data.
  - If the matching channel has fwd_pend_i set, the source is "not ready".
- op2 selection:
  - op2 = imm for I/U/J types.
  - For S type, op2 = rs2 value, and the immediate is carried on imm_o.
  - U/J types: op1 = pc_i.
- hazard = in_valid AND any used source not ready.
- in_ready = rst AND !hazard AND (!out_valid OR out_ready) AND !flush_i.
- Output register acts as a 2-state FSM, EMPTY/FULL:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept while out_ready is high (new instruction replaces the old).
  - FULL→EMPTY on out_ready with no accept.
  - flush_i forces EMPTY on the next edge and has priority over accept.
  - Data fields load only on accept.
- stall_cnt_o increments by 1 per cycle in which hazard=1. It saturates at 2^32-1.
- Redirect (BRANCH_IN_ID=1):
  - jump_o=1 only in the cycle an instruction is accepted.
  - JAL: target pc+imm.
  - JALR: target (op1+imm) with bit 0 cleared.
  - Taken branch: target pc+imm, using the BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned compare on the forwarded operands.
  - Not taken: jump_o=0 and jpc_o=0.
  - A branch waits on a hazard like any other instruction; no redirect is issued while stalled.
- JAL/JALR write the link value (pc+4) through op1_o=pc, op2_o=4.
- Unknown opcode: accepted with wreg_o=0 and illegal_o=1.

Decomposition:
- Shared package holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, EXE_IMM, EXE);
  - funct3 branch codes;
  - the inst_type enum (R/I/S/B/U/J);
  - the XLEN/REG_AW defaults.
- One sub-module, fwd_mux: a single-source priority forwarding resolver with outputs value and ready. It is instantiated twice.

Test Plan:
- ADDI x1,x0,5 with out_ready=1: out_valid next cycle, op1_o=0, op2_o=5, wd_o=1, wreg_o=1.
- ADD x3,x1,x2 with ch1={x1,7} and ch0={x1,9} both valid, regfile x2=3: op1_o=9 (channel 0 wins), op2_o=3.
- LW pending on ch0 for x1 + ADD x3,x1,x2: in_ready=0 for 2 cycles, stall_cnt_o=2. Then pend drops, data=0x10 forwarded, instruction accepted.
- BEQ x1,x2,+8 at pc=0x100 with x1==x2: jump_o=1 and jpc_o=0x108 in the accept cycle. Repeat with x1!=x2: jump_o=0.
- Output FULL with out_ready=0 for 3 cycles: in_ready=0 and outputs held stable. flush_i in cycle 2: out_valid=0 next cycle.
- rst low mid-stall: all outputs 0 on the next edge; x0 used as source or destination never stalls and always reads 0.

Source files
------------

// File: rtl/id_stage_fwd_pkg.sv
// Shared decode definitions for the forwarding decode stage: opcodes, branch codes,
// instruction formats and the RV32I immediate generator.
package id_stage_fwd_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_EXE_IMM = 7'b0010011;
  localparam logic [6:0] OP_EXE     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J} inst_type_e;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  // 32-bit immediate for a given format; R type carries no immediate.
  function automatic logic [31:0] imm_of(input logic [31:0] inst, input inst_type_e t);
    case (t)
      TYPE_I:  imm_of = {{20{inst[31]}}, inst[31:20]};
      TYPE_S:  imm_of = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      TYPE_B:  imm_of = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      TYPE_U:  imm_of = {inst[31:12], 12'b0};
      TYPE_J:  imm_of = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_of = 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_fwd_fwd_mux.sv
// Single-source operand resolver: x0, then the lowest-index matching forwarding
// channel, then the regfile. ready drops while the matching channel is still pending.
module fwd_mux
  import id_stage_fwd_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pend,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]           value,
  output logic                      ready
);

  logic hit;

  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    value = rf_data;
    ready = 1'b1;
    hit   = 1'b0;
    if (addr == '0) begin
      value = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_valid[i] && (fwd_addr[i*REG_AW +: REG_AW] == addr)) begin
          hit   = 1'b1;
          value = fwd_data[i*XLEN +: XLEN];
          ready = ~fwd_pend[i];
        end
      end
    end
  end

endmodule

// File: rtl/id_stage_fwd.sv
// RV32I decode stage with N-channel forwarding, load-use stall detection,
// in-ID branch resolution and a valid/ready output register feeding EX.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int NUM_FWD      = 2,
  parameter bit BRANCH_IN_ID = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      flush_i,
  output logic [REG_AW-1:0]         rs1_addr_o,
  output logic [REG_AW-1:0]         rs2_addr_o,
  input  logic [XLEN-1:0]           rs1_data_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD-1:0]        fwd_pend_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           pc_o,
  output logic [6:0]                aluop_o,
  output logic [2:0]                funct3_o,
  output logic [6:0]                funct7_o,
  output logic [XLEN-1:0]           op1_o,
  output logic [XLEN-1:0]           op2_o,
  output logic [XLEN-1:0]           imm_o,
  output logic                      wreg_o,
  output logic [REG_AW-1:0]         wd_o,
  output logic                      illegal_o,
  output logic                      jump_o,
  output logic [XLEN-1:0]           jpc_o,
  output logic [31:0]               stall_cnt_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  inst_type_e        itype;
  logic              known;
  logic              use_rs1, use_rs2;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              rs1_rdy, rs2_rdy;
  logic              hazard, accept;
  logic              taken;
  logic [XLEN-1:0]   op1_d, op2_d, jalr_sum;
  logic              wreg_d;
  logic [REG_AW-1:0] wd_d;
  out_state_e        state_q, state_d;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  always_comb begin
    itype = TYPE_R;
    known = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC:             itype = TYPE_U;
      OP_JAL:                       itype = TYPE_J;
      OP_JALR, OP_LOAD, OP_EXE_IMM: itype = TYPE_I;
      OP_BRANCH:                    itype = TYPE_B;
      OP_STORE:                     itype = TYPE_S;
      OP_EXE:                       itype = TYPE_R;
      default:                      known = 1'b0;
    endcase
  end

  assign use_rs1 = known && (itype inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B});
  assign use_rs2 = known && (itype inside {TYPE_R, TYPE_S, TYPE_B});

  // An unused source reads x0, which resolves to 0 and is always ready.
  assign rs1_addr_o = use_rs1 ? REG_AW'(inst_i[19:15]) : '0;
  assign rs2_addr_o = use_rs2 ? REG_AW'(inst_i[24:20]) : '0;

  assign imm32 = known ? imm_of(inst_i, itype) : 32'b0;
  assign imm   = XLEN'($signed(imm32));

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .addr      (rs1_addr_o),
    .rf_data   (rs1_data_i),
    .fwd_valid (fwd_valid_i),
    .fwd_pend  (fwd_pend_i),
    .fwd_addr  (fwd_addr_i),
    .fwd_data  (fwd_data_i),
    .value     (rs1_val),
    .ready     (rs1_rdy)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .addr      (rs2_addr_o),
    .rf_data   (rs2_data_i),
    .fwd_valid (fwd_valid_i),
    .fwd_pend  (fwd_pend_i),
    .fwd_addr  (fwd_addr_i),
    .fwd_data  (fwd_data_i),
    .value     (rs2_val),
    .ready     (rs2_rdy)
  );

  assign hazard   = in_valid & ~(rs1_rdy & rs2_rdy);
  assign in_ready = rst & ~hazard & (~out_valid | out_ready) & ~flush_i;
  assign accept   = in_valid & in_ready;

  // Jumps pass the link value pc+4 to EX as op1 + op2.
  always_comb begin
    op1_d = rs1_val;
    op2_d = rs2_val;
    case (itype)
      TYPE_U: begin
        op1_d = pc_i;
        op2_d = imm;
      end
      TYPE_J: begin
        op1_d = pc_i;
        op2_d = XLEN'(4);
      end
      TYPE_I: begin
        if (opcode == OP_JALR) begin
          op1_d = pc_i;
          op2_d = XLEN'(4);
        end else begin
          op2_d = imm;
        end
      end
      default: ;
    endcase
  end

  assign wreg_d = known && !(itype inside {TYPE_S, TYPE_B});
  assign wd_d   = wreg_d ? REG_AW'(inst_i[11:7]) : '0;

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_val + imm;

  always_comb begin
    jump_o = 1'b0;
    jpc_o  = '0;
    if (BRANCH_IN_ID && accept) begin
      if (opcode == OP_JAL) begin
        jump_o = 1'b1;
        jpc_o  = pc_i + imm;
      end else if (opcode == OP_JALR) begin
        jump_o = 1'b1;
        jpc_o  = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (opcode == OP_BRANCH && taken) begin
        jump_o = 1'b1;
        jpc_o  = pc_i + imm;
      end
    end
  end

  // Output register occupancy; flush wins over a simultaneous accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (accept) state_d = OUT_FULL;
      OUT_FULL:  if (!accept && out_ready) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
    if (flush_i) state_d = OUT_EMPTY;
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= OUT_EMPTY;
    else      state_q <= state_d;
  end

  assign out_valid = (state_q == OUT_FULL);

  // NOTE: the payload registers are reset too, because EX and the bench expect
  // a clean all-zero bundle after reset rather than stale decode results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_o      <= '0;
      aluop_o   <= '0;
      funct3_o  <= '0;
      funct7_o  <= '0;
      op1_o     <= '0;
      op2_o     <= '0;
      imm_o     <= '0;
      wreg_o    <= 1'b0;
      wd_o      <= '0;
      illegal_o <= 1'b0;
    end else if (accept) begin
      pc_o      <= pc_i;
      aluop_o   <= opcode;
      funct3_o  <= funct3;
      funct7_o  <= inst_i[31:25];
      op1_o     <= op1_d;
      op2_o     <= op2_d;
      imm_o     <= imm;
      wreg_o    <= wreg_d;
      wd_o      <= wd_d;
      illegal_o <= ~known;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                              stall_cnt_o <= '0;
    else if (hazard && stall_cnt_o != '1)  stall_cnt_o <= stall_cnt_o + 32'd1;
  end

endmodule
